// File: rtl/psum_drain_pkg.sv
// ---------------------------------------------------------------------------
// psum_drain_pkg
// Shared definitions for the OFIFO -> PMEM partial-sum drain block:
//   - default geometry (PE columns, partial-sum width, PMEM address width,
//     words per kij pass, kij passes per layer)
//   - derived PMEM region size and counter widths
//   - drain FSM state encoding
//   - cnt_w(): counter width helper that never returns zero
// ---------------------------------------------------------------------------
package psum_drain_pkg;

  localparam int COL      = 8;
  localparam int PSUM_BW  = 16;
  localparam int ADDR_BW  = 11;
  localparam int LEN_ONIJ = 4;
  localparam int LEN_KIJ  = 9;

  localparam int PMEM_WORDS = LEN_KIJ * LEN_ONIJ;

  // Width needed to hold values 0..n-1; at least one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REM_W  = cnt_w(LEN_ONIJ + 1);
  localparam int KCNT_W = cnt_w(LEN_KIJ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/psum_drain_if.sv
// ---------------------------------------------------------------------------
// psum_drain_if
// Bundles the OFIFO read handshake and the PMEM write port seen by the
// partial-sum drain block.
//   ofifo_valid : OFIFO holds at least one word (first-word-fall-through)
//   ofifo_data  : OFIFO head word, col*psum_bw bits
//   ofifo_rd    : pop strobe
//   pmem_cen    : PMEM chip enable, active-low
//   pmem_wen    : PMEM write enable, active-low
//   pmem_addr   : PMEM address
//   pmem_d      : PMEM write data
// Modports:
//   master : the drain block (pops the OFIFO, drives the PMEM port)
//   slave  : the surrounding core / environment
// ---------------------------------------------------------------------------
interface psum_drain_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
);

  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_data;
  logic                     ofifo_rd;
  logic                     pmem_cen;
  logic                     pmem_wen;
  logic [addr_bw-1:0]       pmem_addr;
  logic [col*psum_bw-1:0]   pmem_d;

  modport master (
    input  ofifo_valid,
    input  ofifo_data,
    output ofifo_rd,
    output pmem_cen,
    output pmem_wen,
    output pmem_addr,
    output pmem_d
  );

  modport slave (
    output ofifo_valid,
    output ofifo_data,
    input  ofifo_rd,
    input  pmem_cen,
    input  pmem_wen,
    input  pmem_addr,
    input  pmem_d
  );

endinterface

// File: rtl/psum_drain.sv
// ---------------------------------------------------------------------------
// psum_drain
// Drains exactly len_onij output-pixel words from the OFIFO per kij pass and
// writes them to PMEM at an auto-incrementing address. The write pointer
// wraps modulo len_kij*len_onij and restarts at 0 after the last kij pass of
// a layer.
// Ports:
//   clk        : core clock, rising edge
//   reset      : asynchronous, active-low
//   clear      : synchronous; zeroes write pointer and pass counter in IDLE
//   start      : begin one kij pass (sampled in IDLE only, never queued)
//   bus        : OFIFO handshake + PMEM write port (psum_drain_if.master)
//   busy       : pass in progress (DRAIN or FLUSH)
//   done       : one-cycle pulse at the end of each pass
//   layer_done : one-cycle pulse together with done for the last kij pass
// Only ofifo_rd is combinational; every other output is registered.
// ---------------------------------------------------------------------------
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int col      = COL,
  parameter int psum_bw  = PSUM_BW,
  parameter int addr_bw  = ADDR_BW,
  parameter int len_onij = LEN_ONIJ,
  parameter int len_kij  = LEN_KIJ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  psum_drain_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              layer_done
);

  localparam int WORD_W   = col * psum_bw;
  localparam int REGION_W = len_kij * len_onij;
  localparam int RM_W     = cnt_w(len_onij + 1);
  localparam int KC_W     = cnt_w(len_kij);
  localparam int WP_W     = cnt_w(REGION_W);

  localparam logic [RM_W-1:0] REM_LOAD  = RM_W'(len_onij);
  localparam logic [RM_W-1:0] REM_LAST  = RM_W'(1);
  localparam logic [KC_W-1:0] KCNT_LAST = KC_W'(len_kij - 1);
  localparam logic [WP_W-1:0] WP_LAST   = WP_W'(REGION_W - 1);

  state_t            state;
  logic [WP_W-1:0]   wp;
  logic [KC_W-1:0]   kcnt;
  logic [RM_W-1:0]   remaining;
  logic              pop;

  // Write stage registers: one cycle behind the pop that produced them.
  logic              wr_cen_p1;
  logic              wr_wen_p1;
  logic [addr_bw-1:0] wr_addr_p1;
  logic [WORD_W-1:0] wr_data_p1;

  // Pop combinationally so an empty FIFO never sees a read strobe and a
  // stalled pass resumes on the very cycle valid returns.
  assign pop          = (state == ST_DRAIN) && bus.ofifo_valid && (remaining != '0);
  assign bus.ofifo_rd = pop;

  assign bus.pmem_cen  = wr_cen_p1;
  assign bus.pmem_wen  = wr_wen_p1;
  assign bus.pmem_addr = wr_addr_p1;
  assign bus.pmem_d    = wr_data_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wp         <= '0;
      kcnt       <= '0;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      layer_done <= 1'b0;
      wr_cen_p1  <= 1'b1;
      wr_wen_p1  <= 1'b1;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      // Strobes and pulses fall back to idle unless this cycle asserts them.
      wr_cen_p1  <= 1'b1;
      wr_wen_p1  <= 1'b1;
      done       <= 1'b0;
      layer_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          // clear acts before start, so a combined clear+start drains to 0.
          if (clear) begin
            wp   <= '0;
            kcnt <= '0;
          end
          if (start) begin
            state     <= ST_DRAIN;
            remaining <= REM_LOAD;
            busy      <= 1'b1;
          end
        end

        // ---- pop stage -> write stage (p1) ----
        ST_DRAIN: begin
          if (pop) begin
            wr_data_p1 <= bus.ofifo_data;
            wr_addr_p1 <= addr_bw'(wp);
            wr_cen_p1  <= 1'b0;
            wr_wen_p1  <= 1'b0;
            wp         <= (wp == WP_LAST) ? '0 : wp + 1'b1;
            remaining  <= remaining - 1'b1;
            if (remaining == REM_LAST) begin
              state <= ST_FLUSH;
            end
          end
        end

        // The final write strobe is on the bus during this state.
        ST_FLUSH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (kcnt == KCNT_LAST) begin
            kcnt       <= '0;
            wp         <= '0;
            layer_done <= 1'b1;
          end else begin
            kcnt <= kcnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
